// File: rtl/cla_adder_4bit.sv
// -----------------------------------------------------------------------------
// cla_adder_4bit
//
// 4-bit carry-lookahead adder slice: {c_out, Output} = A + B + c_in.
// Meant to be chained four-wide through c_in/c_out to build a 16-bit
// adder/subtractor. The parent ANDs the ready flags. Subtraction is handled
// upstream by conditioning B, so this slice only adds.
//
// Ports:
//   clk     in   1  rising-edge clock
//   reset   in   1  asynchronous, active-high reset
//   en      in   1  qualifies the result and feeds the ready register
//   c_in    in   1  carry into bit 0
//   A       in   4  addend
//   B       in   4  addend (already conditioned by the parent)
//   Output  out  4  sum bits [3:0]
//   c_out   out  1  carry out of bit 3
//   ready   out  1  registered result-valid flag (ready <= en each edge)
//
// Configuration macro: CLA_ADDER_OUTREG_EN
//   undefined (default): Output/c_out are combinational and forced to 0
//                        while en = 0.
//   defined:             Output/c_out are registered. They load on an edge
//                        with en = 1, hold while en = 0, and clear on reset.
// -----------------------------------------------------------------------------
module cla_adder_4bit (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       c_in,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] Output,
  output logic       c_out,
  output logic       ready
);

  logic [3:0] g;      // generate
  logic [3:0] p;      // propagate
  logic [4:0] c;      // c[0] = c_in, c[4] = carry out
  logic [3:0] sum;

  // Every carry is a flat sum-of-products of g/p/c_in. No carry depends on
  // the carry below it, so the depth is constant across bit positions.
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
    sum  = p ^ c[3:0];
  end

  // ready tracks en one edge later.
  logic ready_d;
  logic ready_q;

  always_comb begin
    ready_d = en;
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: flops use non-blocking (<=) so every register samples pre-edge values.
    if (reset) ready_q <= 1'b0;
    else       ready_q <= ready_d;
  end

  assign ready = ready_q;

`ifdef CLA_ADDER_OUTREG_EN
  logic [3:0] output_d;
  logic [3:0] output_q;
  logic       c_out_d;
  logic       c_out_q;

  // Load on en, otherwise hold. The result then appears in the same cycle
  // that ready rises.
  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    output_d = output_q;
    c_out_d  = c_out_q;
    if (en) begin
      output_d = sum;
      c_out_d  = c[4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      output_q <= 4'b0000;
      c_out_q  <= 1'b0;
    end else begin
      output_q <= output_d;
      c_out_q  <= c_out_d;
    end
  end

  assign Output = output_q;
  assign c_out  = c_out_q;
`else
  // Zero-latency path. Chained slices settle within one cycle.
  always_comb begin
    Output = 4'b0000;
    c_out  = 1'b0;
    if (en) begin
      Output = sum;
      c_out  = c[4];
    end
  end
`endif

endmodule

// File: tb/tb_cla_adder_4bit.sv
// -----------------------------------------------------------------------------
// tb_cla_adder_4bit
//
// Self-checking bench for cla_adder_4bit. Works in the default combinational
// build and in the CLA_ADDER_OUTREG_EN build.
//
// Each applied operand set pushes its expected {c_out, Output} onto a
// scoreboard queue. The bench pops that entry once the DUT result is due:
// 1 ns after the drive in the combinational build, or 1 ns after the next
// rising edge in the registered build.
// -----------------------------------------------------------------------------
module tb_cla_adder_4bit;

  logic       clk;
  logic       reset;
  logic       en;
  logic       c_in;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] Output;
  logic       c_out;
  logic       ready;

  int total = 0;
  int bad   = 0;

  logic [4:0] q_exp[$];
  logic [4:0] mdl_q = 5'd0;  // model of the registered result (OUTREG build)

  cla_adder_4bit dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .c_in   (c_in),
    .A      (A),
    .B      (B),
    .Output (Output),
    .c_out  (c_out),
    .ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_sum(input string tag);
    logic [4:0] exp;
    if (q_exp.size() == 0) begin
      check({tag, "_no_expected"}, 8'd1, 8'd0);
    end else begin
      exp = q_exp.pop_front();
      check(tag, 8'({c_out, Output}), 8'(exp));
    end
  endtask

  // Drive one operand set away from the clock edge and compare when the
  // result is due.
  task automatic apply(input logic [3:0] a, input logic [3:0] b,
                       input logic ci, input logic e, input string tag);
    logic [4:0] sum;
    @(negedge clk);
    A    = a;
    B    = b;
    c_in = ci;
    en   = e;
    sum  = 5'(a) + 5'(b) + 5'(ci);
`ifdef CLA_ADDER_OUTREG_EN
    if (e) mdl_q = sum;
    q_exp.push_back(mdl_q);
    @(posedge clk);
    #1;
    check({tag, "_rdy"}, 8'(ready), 8'(e));
`else
    q_exp.push_back(e ? sum : 5'd0);
    #1;
`endif
    check_sum(tag);
  endtask

  task automatic ready_after_edge(input logic exp, input string tag);
    @(posedge clk);
    #1;
    check(tag, 8'(ready), 8'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    c_in  = 1'b0;
    A     = 4'd0;
    B     = 4'd0;

    // Asserting reset before any clock edge must clear ready on its own.
    #2 reset = 1'b1;
    en = 1'b1;
    #1 check("rst_async_ready", 8'(ready), 8'd0);
    mdl_q = 5'd0;

    // Keep reset high with en = 1 while the clock runs.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("rst_hold_ready", 8'(ready), 8'd0);
    end

    // Release reset. ready rises on the next edge.
    @(negedge clk);
    reset = 1'b0;
    ready_after_edge(1'b1, "rst_release_ready");

    // Directed sums.
    apply(4'd3, 4'd5, 1'b0, 1'b1, "add_3_5");
    apply(4'd3, 4'd5, 1'b1, 1'b1, "add_3_5_cin");
    apply(4'hF, 4'h0, 1'b1, 1'b1, "prop_F_0_cin");
    apply(4'hF, 4'hF, 1'b1, 1'b1, "max_F_F_cin");
    apply(4'b1000, 4'b1000, 1'b0, 1'b1, "gen_msb");

    // Exhaustive sweep over {A, B, c_in}.
    for (int i = 0; i < 512; i++) begin
      logic [8:0] v;
      v = 9'(i);
      apply(v[8:5], v[4:1], v[0], 1'b1, "sweep");
    end

    // Enable low: combinational build drives 0, registered build holds.
    apply(4'd7, 4'd7, 1'b0, 1'b0, "en_off");
    ready_after_edge(1'b0, "en_off_ready");
    apply(4'd7, 4'd7, 1'b0, 1'b1, "en_on");
    ready_after_edge(1'b1, "en_on_ready");

    // Load, then drop en with different operands.
    apply(4'd2, 4'd9, 1'b1, 1'b1, "a2_b9_cin");
    apply(4'd5, 4'd5, 1'b0, 1'b0, "hold");

    // Raise en, let one edge pass, then assert reset between edges.
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 check("pre_rst_ready", 8'(ready), 8'd1);
    #1 reset = 1'b1;
`ifdef CLA_ADDER_OUTREG_EN
    mdl_q = 5'd0;
    q_exp.push_back(5'd0);
`else
    q_exp.push_back(5'd10);
`endif
    #1;
    check("midop_rst_ready", 8'(ready), 8'd0);
    check_sum("midop_rst_sum");

    ready_after_edge(1'b0, "midop_rst_hold_ready");
    @(negedge clk);
    reset = 1'b0;
    ready_after_edge(1'b1, "midop_release_ready");

    check("scoreboard_empty", 8'(q_exp.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
